// File: rtl/gpio_pkg.sv
// Shared GPIO constants used by the switch debouncer and the GPIO top level.
package gpio_pkg;

    // Width of the board switch bank SW[17:0]
    localparam int unsigned NSW = 18;

    // 10 ms of stability at a 50 MHz ACLK
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage : gpio_pkg

// File: rtl/debounce_bit.sv
// Single-bit switch debouncer: two-flop synchronizer, stability counter and accepted level.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic db_o,
    output logic chg_o
);

    localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q,    db_d;
    logic          chg_q,   chg_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Next-state: synchronize, count consecutive disagreement, accept at the terminal count
    always_comb begin
        sync1_d = sw_i;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        chg_d   = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset wins over every other update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    assign db_o  = db_q;
    assign chg_o = chg_q;

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// Debouncer for the board switch bank: one independent debounce_bit per switch.
module sw_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned NBITS           = NSW,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             ACLK,
    input  logic             RESET_N,
    input  logic [NBITS-1:0] SW,
    output logic [NBITS-1:0] SW_DB,
    output logic [NBITS-1:0] SW_CHG,
    output logic             ANY_CHG
);

    // One debouncer per switch bit
    for (genvar i = 0; i < int'(NBITS); i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (ACLK),
            .rst_n(RESET_N),
            .sw_i (SW[i]),
            .db_o (SW_DB[i]),
            .chg_o(SW_CHG[i])
        );
    end

    // Interrupt-style summary of the registered change pulses
    assign ANY_CHG = |SW_CHG;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce with DEBOUNCE_CYCLES=4 (latency 6 edges).
module tb_sw_debounce;

    localparam int unsigned NB = 18;
    localparam int unsigned DC = 4;

    logic          ACLK;
    logic          RESET_N;
    logic [NB-1:0] SW;
    logic [NB-1:0] SW_DB;
    logic [NB-1:0] SW_CHG;
    logic          ANY_CHG;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] exp_db;
    logic [NB-1:0] exp_chg;
    logic [NB-1:0] exp_db_now;
    logic          exp_any;

    sw_debounce #(
        .NBITS(NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .ACLK   (ACLK),
        .RESET_N(RESET_N),
        .SW     (SW),
        .SW_DB  (SW_DB),
        .SW_CHG (SW_CHG),
        .ANY_CHG(ANY_CHG)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // One rising edge, then settle on the falling edge where outputs are sampled and inputs driven
    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Reset with held inputs; all accepted levels go back to zero
    task automatic do_reset(input int cycles);
        RESET_N = 1'b0;
        repeat (cycles) step();
        RESET_N = 1'b1;
        exp_db  = '0;
    endtask

    task automatic test_reset();
        SW      = '1;
        RESET_N = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (SW_DB !== '0) begin errors++; $display("FAIL reset_db cyc %0d: got %h expected %h", c, SW_DB, 18'h0); end
            checks++;
            if (SW_CHG !== '0) begin errors++; $display("FAIL reset_chg cyc %0d: got %h expected %h", c, SW_CHG, 18'h0); end
            checks++;
            if (ANY_CHG !== 1'b0) begin errors++; $display("FAIL reset_any cyc %0d: got %b expected 0", c, ANY_CHG); end
        end
        RESET_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? 18'h3FFFF : 18'h0;
            exp_chg    = (e == 6) ? 18'h3FFFF : 18'h0;
            exp_any    = (e == 6);
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL post_reset_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL post_reset_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
            checks++;
            if (ANY_CHG !== exp_any) begin errors++; $display("FAIL post_reset_any edge %0d: got %b expected %b", e, ANY_CHG, exp_any); end
        end
        SW = '0;
        do_reset(2);
    endtask

    task automatic test_clean_edge();
        SW[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? (exp_db | 18'h00001) : exp_db;
            exp_chg    = (e == 6) ? 18'h00001 : 18'h0;
            exp_any    = (e == 6);
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL clean_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL clean_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
            checks++;
            if (ANY_CHG !== exp_any) begin errors++; $display("FAIL clean_any edge %0d: got %b expected %b", e, ANY_CHG, exp_any); end
        end
        exp_db = exp_db | 18'h00001;
    endtask

    task automatic test_glitch();
        SW[3] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) SW[3] = 1'b0;
            step();
            checks++;
            if (SW_DB !== exp_db) begin errors++; $display("FAIL glitch_db edge %0d: got %h expected %h", e, SW_DB, exp_db); end
            checks++;
            if (SW_CHG !== '0) begin errors++; $display("FAIL glitch_chg edge %0d: got %h expected %h", e, SW_CHG, 18'h0); end
        end
    endtask

    task automatic test_bounce();
        SW[5] = 1'b1;
        step();
        SW[5] = 1'b0;
        step();
        checks++;
        if (SW_CHG !== '0) begin errors++; $display("FAIL bounce_early_chg: got %h expected %h", SW_CHG, 18'h0); end
        SW[5] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? (exp_db | 18'h00020) : exp_db;
            exp_chg    = (e == 6) ? 18'h00020 : 18'h0;
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL bounce_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL bounce_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
        end
        exp_db = exp_db | 18'h00020;
    endtask

    task automatic test_simultaneous();
        SW[17] = 1'b1;
        SW[1]  = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? (exp_db | 18'h20002) : exp_db;
            exp_chg    = (e == 6) ? 18'h20002 : 18'h0;
            exp_any    = (e == 6);
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL simul_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL simul_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
            checks++;
            if (ANY_CHG !== exp_any) begin errors++; $display("FAIL simul_any edge %0d: got %b expected %b", e, ANY_CHG, exp_any); end
        end
        exp_db = exp_db | 18'h20002;
    endtask

    task automatic test_fall();
        SW[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? (exp_db & ~18'h00001) : exp_db;
            exp_chg    = (e == 6) ? 18'h00001 : 18'h0;
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL fall_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL fall_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
        end
        exp_db = exp_db & ~18'h00001;
        SW[0]  = 1'b1;
        repeat (8) step();
        exp_db = exp_db | 18'h00001;
        checks++;
        if (SW_DB !== exp_db) begin errors++; $display("FAIL refill_db: got %h expected %h", SW_DB, exp_db); end
    endtask

    task automatic test_reset_mid();
        SW[2] = 1'b1;
        repeat (2) step();
        RESET_N = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            step();
            checks++;
            if (SW_CHG !== '0) begin errors++; $display("FAIL midrst_chg cyc %0d: got %h expected %h", c, SW_CHG, 18'h0); end
            checks++;
            if (SW_DB !== '0) begin errors++; $display("FAIL midrst_db cyc %0d: got %h expected %h", c, SW_DB, 18'h0); end
        end
        RESET_N = 1'b1;
        // Every switch still held high is re-debounced after release
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_db_now = (e >= 6) ? 18'h20027 : 18'h0;
            exp_chg    = (e == 6) ? 18'h20027 : 18'h0;
            checks++;
            if (SW_DB !== exp_db_now) begin errors++; $display("FAIL midrst_rel_db edge %0d: got %h expected %h", e, SW_DB, exp_db_now); end
            checks++;
            if (SW_CHG !== exp_chg) begin errors++; $display("FAIL midrst_rel_chg edge %0d: got %h expected %h", e, SW_CHG, exp_chg); end
        end
        exp_db = 18'h20027;
    endtask

    initial begin
        RESET_N = 1'b0;
        SW      = '0;
        exp_db  = '0;
        @(negedge ACLK);
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_fall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sw_debounce
